// File: rtl/piano_note_scheduler.sv
// piano_note_scheduler: queues debounced key requests in a small FIFO and plays
// them one at a time with a fixed note length followed by a fixed silent gap.
// A built-in Do..Si demo scale runs when requested and no key is pending.
// note: 0 = silence, 1..7 = Do..Si. All outputs are registered.

module piano_note_scheduler #(
    parameter logic [31:0] NOTE_CNT_MAX = 32'd124_999_999,
    parameter logic [31:0] GAP_CNT_MAX  = 32'd12_499_999,
    parameter int          FIFO_DEPTH   = 4,
    localparam int         PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int         LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       key_pulse,
    input  logic             demo_start,
    input  logic             demo_stop,
    output logic [3:0]       note,
    output logic             note_start,
    output logic             busy,
    output logic             demo_active,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_full,
    output logic             key_dropped
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t           state;
    logic [31:0]      dur_cnt;
    logic [2:0]       demo_step;

    logic [2:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             key_valid;
    logic             key_multi;
    logic [2:0]       key_code;
    logic [2:0]       fifo_head;
    logic             fifo_empty;
    logic             level_full;
    logic             play_end;
    logic             gap_end;
    logic             abort;
    logic             pop;
    logic             push;
    logic [LVL_W-1:0] level_next;

    // Priority-encode the key pulses; scanning downwards leaves the lowest set bit.
    always_comb begin
        key_code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (key_pulse[i]) begin
                key_code = 3'(i + 1);
            end
        end
    end

    // Queue bookkeeping and sequencer decision terms shared by both registers.
    always_comb begin
        key_valid  = |key_pulse;
        key_multi  = (key_pulse & (key_pulse - 7'd1)) != 7'd0;
        fifo_head  = fifo_mem[rd_ptr];
        fifo_empty = (fifo_level == '0);
        level_full = (fifo_level == LVL_W'(FIFO_DEPTH));
        play_end   = (state == PLAY) && (dur_cnt == NOTE_CNT_MAX);
        gap_end    = (state == GAP) && (dur_cnt == GAP_CNT_MAX);
        abort      = demo_stop && demo_active;
        pop        = !abort && !fifo_empty && ((state == IDLE) || gap_end);
        push       = key_valid && (!level_full || pop);
        level_next = LVL_W'(fifo_level + LVL_W'(push) - LVL_W'(pop));
    end

    // Queue storage is left unreset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= key_code;
        end
    end

    // Queue pointers, occupancy and the dropped-key pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            fifo_full   <= 1'b0;
            key_dropped <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level  <= level_next;
            fifo_full   <= (level_next == LVL_W'(FIFO_DEPTH));
            key_dropped <= key_multi || (key_valid && !push);
        end
    end

    // Sequencer: IDLE -> PLAY -> GAP -> (PLAY | IDLE), with demo abort taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dur_cnt     <= 32'd0;
            demo_step   <= 3'd0;
            note        <= 4'd0;
            note_start  <= 1'b0;
            busy        <= 1'b0;
            demo_active <= 1'b0;
        end else begin
            note_start <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                dur_cnt     <= 32'd0;
                demo_step   <= 3'd0;
                note        <= 4'd0;
                busy        <= 1'b0;
                demo_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        dur_cnt <= 32'd0;
                        if (pop) begin
                            state      <= PLAY;
                            note       <= {1'b0, fifo_head};
                            note_start <= 1'b1;
                            busy       <= 1'b1;
                        end else if (demo_start && !demo_stop) begin
                            state       <= PLAY;
                            note        <= 4'd1;
                            note_start  <= 1'b1;
                            busy        <= 1'b1;
                            demo_active <= 1'b1;
                            demo_step   <= 3'd1;
                        end
                    end
                    PLAY: begin
                        if (play_end) begin
                            state   <= GAP;
                            note    <= 4'd0;
                            dur_cnt <= 32'd0;
                        end else begin
                            dur_cnt <= dur_cnt + 32'd1;
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            dur_cnt <= 32'd0;
                            if (pop) begin
                                state       <= PLAY;
                                note        <= {1'b0, fifo_head};
                                note_start  <= 1'b1;
                                demo_active <= 1'b0;
                                demo_step   <= 3'd0;
                            end else if (demo_active && (demo_step < 3'd7)) begin
                                state      <= PLAY;
                                note       <= {1'b0, 3'(demo_step + 3'd1)};
                                note_start <= 1'b1;
                                demo_step  <= 3'(demo_step + 3'd1);
                            end else begin
                                state       <= IDLE;
                                busy        <= 1'b0;
                                demo_active <= 1'b0;
                                demo_step   <= 3'd0;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + 32'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        dur_cnt <= 32'd0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
